multi_clock_divider: RTL and testbench

Parametrised, multi-channel successor to the single-rate clock divider. It generates NUM_CH independent divided clocks, each with a programmable period and duty, plus a one-cycle tick per period. Each channel runs free or as a one-shot. Configuration is double-buffered, so reprogramming never glitches a running output. It sits between the system clock and the alarm-clock timekeeping, display-multiplex and buzzer logic, replacing per-consumer divider instances.

---
 rtl/multi_clock_divider.sv | 157 +++++++++++++++
 tb/tb_multi_clock_divider.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_clock_divider.sv
`default_nettype none
// ============================================================================
// Module   : multi_clock_divider
// Purpose  : NUM_CH independent programmable clock dividers (period, duty,
//            free-run / one-shot) with double-buffered, glitch-free config.
// Revision : 1.0 - initial release
// ============================================================================
module multi_clock_divider #(
  parameter int NUM_CH = 4,
  parameter int PW     = 27,
  parameter int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_we,
  input  logic [CW-1:0]     cfg_ch,
  input  logic [PW-1:0]     cfg_period,
  input  logic [PW-1:0]     cfg_high,
  input  logic              cfg_oneshot,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] start,
  output logic [NUM_CH-1:0] out_clk,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] done,
  output logic [NUM_CH-1:0] busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] cnt;
    logic [PW-1:0] cnt_nxt;

    logic [PW-1:0] sh_period;
    logic [PW-1:0] sh_high;
    logic          sh_oneshot;

    logic [PW-1:0] act_period;
    logic [PW-1:0] act_high;
    logic          act_oneshot;
    logic [PW-1:0] act_period_nxt;
    logic [PW-1:0] act_high_nxt;
    logic          act_oneshot_nxt;

    logic          sel;
    logic          wrap;
    logic          load;
    logic          run_nxt;
    logic          done_nxt;

    logic          out_clk_r;
    logic          tick_r;
    logic          done_r;
    logic          busy_r;

    // Out-of-range channel indices never match, so such writes are dropped.
    assign sel = cfg_we && (cfg_ch == CW'(i));

    always_comb begin
      wrap            = (state == ST_RUN) && (cnt == act_period - PW'(1));
      load            = (state == ST_IDLE) || wrap;
      act_period_nxt  = act_period;
      act_high_nxt    = act_high;
      act_oneshot_nxt = act_oneshot;
      state_nxt       = state;
      cnt_nxt         = cnt;
      done_nxt        = 1'b0;

      // A write landing in a load cycle bypasses the shadow.
      if (load) begin
        if (sel) begin
          act_period_nxt  = cfg_period;
          act_high_nxt    = cfg_high;
          act_oneshot_nxt = cfg_oneshot;
        end else begin
          act_period_nxt  = sh_period;
          act_high_nxt    = sh_high;
          act_oneshot_nxt = sh_oneshot;
        end
      end

      case (state)
        ST_IDLE: begin
          cnt_nxt = '0;
          if ((act_period_nxt != '0) &&
              (act_oneshot_nxt ? start[i] : en[i])) begin
            state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (wrap) begin
            cnt_nxt = '0;
            // The mode of the period just finished decides how it ends.
            if (act_oneshot) begin
              state_nxt = ST_IDLE;
              done_nxt  = 1'b1;
            end else if (!en[i] || (act_period_nxt == '0)) begin
              state_nxt = ST_IDLE;
            end
          end else begin
            cnt_nxt = cnt + PW'(1);
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase

      run_nxt = (state_nxt == ST_RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state       <= ST_IDLE;
        cnt         <= '0;
        sh_period   <= '0;
        sh_high     <= '0;
        sh_oneshot  <= 1'b0;
        act_period  <= '0;
        act_high    <= '0;
        act_oneshot <= 1'b0;
        out_clk_r   <= 1'b0;
        tick_r      <= 1'b0;
        done_r      <= 1'b0;
        busy_r      <= 1'b0;
      end else begin
        state       <= state_nxt;
        cnt         <= cnt_nxt;
        if (sel) begin
          sh_period  <= cfg_period;
          sh_high    <= cfg_high;
          sh_oneshot <= cfg_oneshot;
        end
        act_period  <= act_period_nxt;
        act_high    <= act_high_nxt;
        act_oneshot <= act_oneshot_nxt;
        out_clk_r   <= run_nxt && (cnt_nxt < act_high_nxt);
        tick_r      <= run_nxt && (cnt_nxt == '0);
        done_r      <= done_nxt;
        busy_r      <= run_nxt;
      end
    end

    assign out_clk[i] = out_clk_r;
    assign tick[i]    = tick_r;
    assign done[i]    = done_r;
    assign busy[i]    = busy_r;
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_clock_divider.sv
`default_nettype none
// Testbench for multi_clock_divider: directed stimulus with a queued
// scoreboard of hand-computed {out_clk, tick, done, busy} per channel and cycle.
module tb_multi_clock_divider;
  localparam int NUM_CH = 5;
  localparam int PW     = 27;
  localparam int CW     = 3;

  logic              clk         = 1'b0;
  logic              reset_n     = 1'b0;
  logic              cfg_we      = 1'b0;
  logic [CW-1:0]     cfg_ch      = '0;
  logic [PW-1:0]     cfg_period  = '0;
  logic [PW-1:0]     cfg_high    = '0;
  logic              cfg_oneshot = 1'b0;
  logic [NUM_CH-1:0] en          = '0;
  logic [NUM_CH-1:0] start       = '0;
  logic [NUM_CH-1:0] out_clk;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] done;
  logic [NUM_CH-1:0] busy;

  multi_clock_divider #(
    .NUM_CH(NUM_CH),
    .PW    (PW),
    .CW    (CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .cfg_oneshot(cfg_oneshot),
    .en         (en),
    .start      (start),
    .out_clk    (out_clk),
    .tick       (tick),
    .done       (done),
    .busy       (busy)
  );

  typedef struct {
    int         cyc;
    int         ch;
    logic [3:0] v;
  } exp_t;

  exp_t  q[$];
  int    cyc    = 0;
  int    checks = 0;
  int    errors = 0;
  string phase  = "reset";

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every expectation due at this cycle is compared mid-cycle.
  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] got;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e   = q.pop_front();
      got = {out_clk[e.ch], tick[e.ch], done[e.ch], busy[e.ch]};
      checks++;
      if (e.cyc != cyc || got !== e.v) begin
        errors++;
        $display("FAIL %s ch%0d cyc %0d: got clk/tick/done/busy=%b required %b (due cyc %0d)",
                 phase, e.ch, cyc, got, e.v, e.cyc);
      end
    end
  end

  task automatic push_at(input int c, input int ch, input logic [3:0] v);
    exp_t e;
    e.cyc = c;
    e.ch  = ch;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic exp_next(input int ch, input logic [3:0] v);
    push_at(cyc + 1, ch, v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int ch, input int p, input int h, input logic os);
    cfg_we      = 1'b1;
    cfg_ch      = CW'(ch);
    cfg_period  = PW'(p);
    cfg_high    = PW'(h);
    cfg_oneshot = os;
    step();
    cfg_we      = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    // Reset state
    for (int k = 0; k < 2; k++) begin
      for (int ch = 0; ch < NUM_CH; ch++) exp_next(ch, 4'b0000);
      step();
    end
    reset_n = 1'b1;

    // P=4 H=2 free-run: 1,1,0,0 with tick on cnt 0
    phase = "freerun_p4h2";
    cfg(0, 4, 2, 1'b0);
    en[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      c = k % 4;
      exp_next(0, {(c < 2), (c == 0), 1'b0, 1'b1});
      step();
    end

    // Write P=6 H=3 at cnt=1: current period must finish unchanged
    phase = "midperiod_cfg";
    cfg_we = 1'b1; cfg_ch = 3'd0; cfg_period = PW'(6); cfg_high = PW'(3); cfg_oneshot = 1'b0;
    exp_next(0, 4'b0001);
    step();
    cfg_we = 1'b0;
    exp_next(0, 4'b0001);
    step();
    for (int j = 0; j < 6; j++) begin
      exp_next(0, {(j < 3), (j == 0), 1'b0, 1'b1});
      step();
    end

    // Write P=3 H=1 exactly on the wrap cycle: applies immediately
    phase = "wrap_bypass";
    cfg_we = 1'b1; cfg_period = PW'(3); cfg_high = PW'(1);
    exp_next(0, 4'b1101);
    step();
    cfg_we = 1'b0;
    exp_next(0, 4'b0001); step();
    exp_next(0, 4'b0001); step();
    en[0] = 1'b0;
    exp_next(0, 4'b0000); step();
    exp_next(0, 4'b0000); step();

    // P=5 H=2, en dropped at cnt=1: period completes then IDLE
    phase = "en_drop";
    cfg(0, 5, 2, 1'b0);
    en[0] = 1'b1;
    exp_next(0, 4'b1101); step();
    exp_next(0, 4'b1001); step();
    en[0] = 1'b0;
    exp_next(0, 4'b0001); step();
    exp_next(0, 4'b0001); step();
    exp_next(0, 4'b0001); step();
    exp_next(0, 4'b0000); step();
    exp_next(0, 4'b0000); step();

    // en dropped at cnt=1, restored at cnt=3: no gap
    phase = "en_toggle";
    en[0] = 1'b1;
    exp_next(0, 4'b1101); step();
    exp_next(0, 4'b1001); step();
    en[0] = 1'b0;
    exp_next(0, 4'b0001); step();
    exp_next(0, 4'b0001); step();
    en[0] = 1'b1;
    exp_next(0, 4'b0001); step();
    exp_next(0, 4'b1101); step();
    exp_next(0, 4'b1001); step();
    en[0] = 1'b0;
    exp_next(0, 4'b0001); step();
    exp_next(0, 4'b0001); step();
    exp_next(0, 4'b0001); step();
    exp_next(0, 4'b0000); step();

    // One-shot P=3 H=1 on ch1, second start while busy ignored
    phase = "oneshot";
    cfg(1, 3, 1, 1'b1);
    start[1] = 1'b1;
    exp_next(1, 4'b1101); step();
    exp_next(1, 4'b0001); step();
    start[1] = 1'b0;
    exp_next(1, 4'b0001); step();
    exp_next(1, 4'b0010); step();
    exp_next(1, 4'b0000); step();
    exp_next(1, 4'b0000); step();

    // P=0: never leaves IDLE
    phase = "p_zero";
    cfg(2, 0, 2, 1'b0);
    en[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_next(2, 4'b0000); step();
    end
    en[2] = 1'b0;

    // H=0, P=3: out_clk low, ticks present
    phase = "h_zero";
    cfg(2, 3, 0, 1'b0);
    en[2] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      c = k % 3;
      exp_next(2, {1'b0, (c == 0), 1'b0, 1'b1}); step();
    end
    en[2] = 1'b0;
    exp_next(2, 4'b0001); step();
    exp_next(2, 4'b0000); step();

    // H=7, P=5: out_clk constantly high
    phase = "h_ge_p";
    cfg(2, 5, 7, 1'b0);
    en[2] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      c = k % 5;
      exp_next(2, {1'b1, (c == 0), 1'b0, 1'b1}); step();
    end
    en[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_next(2, 4'b1001); step();
    end
    exp_next(2, 4'b0000); step();

    // P=1: tick every cycle
    phase = "p_one";
    cfg(2, 1, 1, 1'b0);
    en[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_next(2, 4'b1101); step();
    end
    en[2] = 1'b0;
    exp_next(2, 4'b0000); step();

    // cfg_ch out of range: no channel changes
    phase = "bad_ch";
    cfg(5, 2, 1, 1'b0);
    en[0] = 1'b1; en[3] = 1'b1; en[4] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_next(0, {(k < 2), (k == 0), 1'b0, 1'b1});
      exp_next(3, 4'b0000);
      exp_next(4, 4'b0000);
      step();
    end

    // Asynchronous reset mid-run: outputs drop before the next clk edge
    phase = "async_reset";
    step();
    reset_n = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) push_at(cyc, ch, 4'b0000);
    for (int k = 0; k < 2; k++) begin
      for (int ch = 0; ch < NUM_CH; ch++) exp_next(ch, 4'b0000);
      step();
    end
    reset_n = 1'b1;
    phase = "post_reset";
    for (int k = 0; k < 3; k++) begin
      exp_next(0, 4'b0000); step();
    end
    en = '0;
    cfg(0, 2, 1, 1'b0);
    en[0] = 1'b1;
    exp_next(0, 4'b1101); step();
    exp_next(0, 4'b0001); step();
    exp_next(0, 4'b1101); step();
    en[0] = 1'b0;
    exp_next(0, 4'b0001); step();
    exp_next(0, 4'b0000); step();

    repeat (3) step();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
